// File: rtl/soma_serial_ctrl_pkg.sv
// soma_serial_ctrl_pkg
// Shared definitions for the bit-serial add controller: FSM state
// encoding, the decimal base used by the tens/units split, and the
// bit-counter width helper.
package soma_serial_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_CONV = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    ADD  = ST_ADD,
    CONV = ST_CONV,
    DONE = ST_DONE
  } state_t;

  localparam int DEC_BASE = 10;

  // Bits needed to count operand bit positions 0..width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/soma_serial_ctrl_somador1bit.sv
// Somador1bit
// Combinational 1-bit full adder; the controller reuses one instance for
// every operand bit position.
// Ports:
//   a, b  : operand bits
//   cin   : carry in
//   s     : sum bit
//   cout  : carry out (majority of a, b, cin)
module Somador1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/soma_serial_ctrl.sv
// soma_serial_ctrl
// Bit-serial adder: operands are latched on start, added LSB-first through
// one shared full adder, then the (WIDTH+1)-bit sum is split into decimal
// tens/units by repeated subtraction of ten.
// Ports:
//   clk, rst_n     : clock (rising edge), async active-low reset
//   start          : request, only honoured in IDLE
//   n1, n2, tr0    : operands and carry-in, latched on the accepting edge
//   busy           : high in ADD and CONV
//   done           : one-cycle pulse, result registers valid from this cycle
//   sum, dez, uni  : binary result and its tens/units digits
//
// state | meaning
// IDLE  | waiting for start
// ADD   | one operand bit per cycle through the shared adder
// CONV  | subtract ten per cycle until the remainder is a units digit
// DONE  | result just committed, done pulse
module soma_serial_ctrl
  import soma_serial_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] n1,
  input  logic [WIDTH-1:0] n2,
  input  logic             tr0,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum,
  output logic [3:0]       dez,
  output logic [3:0]       uni
);

  localparam int CW = cnt_width(WIDTH);
  localparam int SW = WIDTH + 1;
  // Remainder is at least 4 bits wide so that ten is representable even
  // when the sum itself is narrower.
  localparam int RW = (SW < 4) ? 4 : SW;
  localparam logic [RW-1:0] DEC_RW = RW'(DEC_BASE);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    wsum_q, wsum_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [3:0]       tens_q, tens_d;
  logic [SW-1:0]    sum_q, sum_d;
  logic [3:0]       dez_q, dez_d, uni_q, uni_d;
  logic             bit_s, bit_c;
  logic [RW-1:0]    sum_ext, rem_sub;

  Somador1bit u_bit (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (bit_s),
    .cout (bit_c)
  );

  assign rem_sub = rem_q - DEC_RW;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    wsum_d  = wsum_q;
    rem_d   = rem_q;
    tens_d  = tens_q;
    sum_d   = sum_q;
    dez_d   = dez_q;
    uni_d   = uni_q;
    sum_ext = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = n1;
          b_d     = n2;
          carry_d = tr0;
          cnt_d   = '0;
          wsum_d  = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        wsum_d[cnt_q] = bit_s;
        carry_d       = bit_c;
        a_d           = a_q >> 1;
        b_d           = b_q >> 1;
        cnt_d         = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          wsum_d[WIDTH] = bit_c;
          sum_ext       = RW'(wsum_d);
          rem_d         = sum_ext;
          tens_d        = '0;
          // A sum already below ten needs no subtraction pass.
          if (sum_ext < DEC_RW) begin
            sum_d   = wsum_d;
            dez_d   = '0;
            uni_d   = sum_ext[3:0];
            state_d = DONE;
          end else begin
            state_d = CONV;
          end
        end
      end
      CONV: begin
        // The subtraction that brings the remainder below ten also commits
        // the result, so CONV lasts exactly floor(sum/10) cycles.
        rem_d  = rem_sub;
        tens_d = tens_q + 4'd1;
        if (rem_sub < DEC_RW) begin
          sum_d   = wsum_q;
          dez_d   = tens_q + 4'd1;
          uni_d   = rem_sub[3:0];
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      wsum_q  <= '0;
      rem_q   <= '0;
      tens_q  <= '0;
      sum_q   <= '0;
      dez_q   <= '0;
      uni_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      wsum_q  <= wsum_d;
      rem_q   <= rem_d;
      tens_q  <= tens_d;
      sum_q   <= sum_d;
      dez_q   <= dez_d;
      uni_q   <= uni_d;
    end
  end

  assign busy = (state_q == ADD) || (state_q == CONV);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign dez  = dez_q;
  assign uni  = uni_q;

endmodule

// File: tb/tb_soma_serial_ctrl.sv
// tb_soma_serial_ctrl
// Self-checking bench for soma_serial_ctrl (WIDTH=4). Expected results come
// from plain arithmetic on the operands: S = n1+n2+tr0, tens = S/10,
// units = S%10, done in cycle WIDTH+S/10+1 after the accepting edge.
module tb_soma_serial_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         tr0 = 1'b0;
  logic [W-1:0] n1 = '0;
  logic [W-1:0] n2 = '0;
  logic         busy, done;
  logic [W:0]   sum;
  logic [3:0]   dez, uni;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_sum  = 0;
  int exp_dez  = 0;
  int exp_uni  = 0;

  soma_serial_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .n1    (n1),
    .n2    (n2),
    .tr0   (tr0),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .dez   (dez),
    .uni   (uni)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack_res(input int s, input int d, input int u);
    return 32'((s << 8) | (d << 4) | u);
  endfunction

  // One operation. chained: the bench is sitting on the negedge of the IDLE
  // cycle with start still high, so the next posedge accepts. inj: cycle in
  // which a stray start with n1=3 is driven (0 = none). keep: leave start high.
  task automatic run_op(input int x, input int y, input int c, input int inj,
                        input bit chained, input bit keep);
    int s, q, done_at;
    logic [31:0] xv, yv;
    s = x + y + c;
    q = s / 10;
    xv = 32'(x);
    yv = 32'(y);
    if (!chained) @(negedge clk);
    n1    = xv[W-1:0];
    n2    = yv[W-1:0];
    tr0   = c[0];
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!keep) start = 1'b0;
    n1  = W'($urandom());
    n2  = W'($urandom());
    tr0 = 1'($urandom());
    done_at = 0;
    for (int cyc = 1; cyc <= 40 && done_at == 0; cyc++) begin
      @(negedge clk);
      if (done) begin
        done_at = cyc;
      end else begin
        if (cyc <= W + q) check_val("busy", 32'(busy), 32'd1);
        check_val("hold", pack_res(int'(sum), int'(dez), int'(uni)),
                  pack_res(exp_sum, exp_dez, exp_uni));
        if (cyc == inj) begin
          start = 1'b1;
          n1    = 4'd3;
        end else if (cyc == inj + 1 && !keep) begin
          start = 1'b0;
        end
      end
    end
    if (!keep) start = 1'b0;
    exp_sum = s;
    exp_dez = q;
    exp_uni = s % 10;
    check_val("done_cycle", 32'(done_at), 32'(W + q + 1));
    check_val("busy_at_done", 32'(busy), 32'd0);
    check_val("sum", 32'(sum), 32'(exp_sum));
    check_val("dez", 32'(dez), 32'(exp_dez));
    check_val("uni", 32'(uni), 32'(exp_uni));
    @(negedge clk);
    check_val("done_width", 32'(done), 32'd0);
    check_val("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_done;
    int x, y, c, inj;

    // Reset held with start high: nothing moves.
    start = 1'b1;
    n1 = 4'd7;
    n2 = 4'd5;
    repeat (3) begin
      @(negedge clk);
      check_val("rst_outputs", {busy, done, 3'b0, sum, dez, uni}, 32'd0);
    end
    start = 1'b0;
    rst_n = 1'b1;

    run_op(7, 5, 0, 0, 1'b0, 1'b0);
    run_op(15, 15, 1, 0, 1'b0, 1'b0);
    run_op(0, 0, 0, 0, 1'b0, 1'b0);
    run_op(7, 5, 0, 2, 1'b0, 1'b0);

    // Reset in the middle of ADD.
    @(negedge clk);
    n1 = 4'd5; n2 = 4'd6; tr0 = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("midrst_busy", 32'(busy), 32'd0);
    check_val("midrst_done", 32'(done), 32'd0);
    check_val("midrst_res", pack_res(int'(sum), int'(dez), int'(uni)), 32'd0);
    saw_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    check_val("midrst_nodone", 32'(saw_done), 32'd0);
    exp_sum = 0; exp_dez = 0; exp_uni = 0;
    rst_n = 1'b1;
    run_op(9, 9, 0, 0, 1'b0, 1'b0);

    // Random operands, sometimes with a stray start while busy.
    for (int i = 0; i < 20; i++) begin
      x   = int'($urandom_range(0, 15));
      y   = int'($urandom_range(0, 15));
      c   = int'($urandom_range(0, 1));
      inj = int'($urandom_range(0, 4));
      run_op(x, y, c, inj, 1'b0, 1'b0);
    end

    // start held high: back-to-back operations.
    run_op(1, 1, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) run_op(1, 1, 0, 0, 1'b1, 1'b1);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_val("final_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
